// File: rtl/ms_timer_pkg.sv
// Shared types and widths for the millisecond timer slice.
package ms_timer_pkg;
  localparam int MS_W      = 32;
  localparam int DUR_W_DEF = 32;
  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;
endpackage

// File: rtl/ms_timer_if.sv
// Load handshake between a configuring master and the ms_timer slave.
interface ms_timer_if #(
  parameter int DUR_W = ms_timer_pkg::DUR_W_DEF
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [DUR_W-1:0] cfg_duration;
  logic             cfg_periodic;

  modport master (output cfg_valid, output cfg_duration, output cfg_periodic, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_duration, input cfg_periodic, output cfg_ready);
endinterface

// File: rtl/ms_tick_sampler.sv
// Resynchronises the free-running ms count and emits the per-cycle increment.
module ms_tick_sampler
  import ms_timer_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic            sys_clk,
  input  logic            sys_rst,
  input  logic [MS_W-1:0] i_ms,
  output logic [MS_W-1:0] o_delta
);
  localparam int PC_W = $clog2(SYNC_STAGES + 1) + 1;

  logic [MS_W-1:0] r_sync [SYNC_STAGES];
  logic [MS_W-1:0] r_ms_prev;
  logic [PC_W-1:0] r_prime_cnt;
  logic            r_prime;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
      r_ms_prev   <= '0;
      r_prime_cnt <= PC_W'(SYNC_STAGES);
      r_prime     <= 1'b0;
    end else begin
      r_sync[0] <= i_ms;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_ms_prev <= r_sync[SYNC_STAGES-1];
      // Hold delta at zero until both ms_s and ms_prev carry real samples.
      if (!r_prime) begin
        if (r_prime_cnt == '0) r_prime <= 1'b1;
        else                   r_prime_cnt <= r_prime_cnt - 1'b1;
      end
    end
  end

  // Unsigned subtraction wraps naturally across the 32-bit rollover.
  assign o_delta = r_prime ? (r_sync[SYNC_STAGES-1] - r_ms_prev) : '0;
endmodule

// File: rtl/ms_timer.sv
// Millisecond duration timer, one-shot or drift-free periodic.
// Optional MS_TIMER_PAUSE_EN adds a pause input that freezes a running timer.
module ms_timer
  import ms_timer_pkg::*;
#(
  parameter int DUR_W       = DUR_W_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic [MS_W-1:0]  milliseconds,
  ms_timer_if.slave        cfg,
  input  logic             stop,
`ifdef MS_TIMER_PAUSE_EN
  input  logic             pause,
`endif
  output logic [DUR_W-1:0] elapsed,
  output logic             busy,
  output logic             expired,
  output logic [CNT_W-1:0] expire_count
);
  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_RUN  = RUN;
  localparam logic [1:0] S_DONE = DONE;
  localparam int SUM_W = ((DUR_W > MS_W) ? DUR_W : MS_W) + 1;

  logic [1:0]       r_state;
  logic [DUR_W-1:0] r_duration;
  logic [DUR_W-1:0] r_elapsed;
  logic             r_periodic;
  logic             r_expired;
  logic [CNT_W-1:0] r_count;

  logic [MS_W-1:0]  w_delta;
  logic             w_pause;
  logic             w_run;
  logic             w_accept;
  logic             w_hit;
  logic             w_reload;
  logic [SUM_W-1:0] w_sum;
  logic [SUM_W-1:0] w_rem;

  ms_tick_sampler #(.SYNC_STAGES(SYNC_STAGES)) u_sampler (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .i_ms    (milliseconds),
    .o_delta (w_delta)
  );

`ifdef MS_TIMER_PAUSE_EN
  assign w_pause = pause;
`else
  assign w_pause = 1'b0;
`endif

  assign w_run         = (r_state == S_RUN);
  assign cfg.cfg_ready = ~w_run;
  assign w_accept      = cfg.cfg_valid & ~w_run;

  assign w_sum    = SUM_W'(r_elapsed) + SUM_W'(w_delta);
  assign w_rem    = w_sum - SUM_W'(r_duration);
  // stop and pause both suppress an expiry that would land this cycle.
  assign w_hit    = w_run & ~stop & ~w_pause & (w_sum >= SUM_W'(r_duration));
  // A zero duration cannot reload without firing every cycle, so it is one-shot.
  assign w_reload = r_periodic & (r_duration != '0);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state    <= S_IDLE;
      r_duration <= '0;
      r_elapsed  <= '0;
      r_periodic <= 1'b0;
      r_expired  <= 1'b0;
      r_count    <= '0;
    end else begin
      r_expired <= w_hit;
      if (w_hit && (r_count != '1)) r_count <= r_count + 1'b1;
      case (r_state)
        S_RUN: begin
          if (stop) begin
            r_state <= S_IDLE;
          end else if (!w_pause) begin
            if (w_hit) begin
              if (w_reload) begin
                r_elapsed <= DUR_W'(w_rem);
              end else begin
                r_elapsed <= r_duration;
                r_state   <= S_DONE;
              end
            end else begin
              r_elapsed <= DUR_W'(w_sum);
            end
          end
        end
        default: begin
          if (w_accept) begin
            r_duration <= cfg.cfg_duration;
            r_periodic <= cfg.cfg_periodic;
            r_elapsed  <= '0;
            r_state    <= S_RUN;
          end else if (stop) begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign elapsed      = r_elapsed;
  assign busy         = w_run;
  assign expired      = r_expired;
  assign expire_count = r_count;
endmodule
